// File: rtl/tetris_game_ctrl.sv
// tetris_game_ctrl: top-level game sequencer for the Tetris core.
//
// Runs the OVER -> NEW -> DRO -> DEL loop. It turns drop-timer ticks and
// board-checker status into per-piece command pulses, and it keeps the
// lines, level and score statistics.
//
// Ports:
//   clk, rst        system clock; asynchronous active-high reset
//   start           single-cycle start pulse (used only in OVER)
//   drop            single-cycle gravity tick from the drop timer
//   collide_below   level: the piece cannot move one row down
//   spawn_blocked   level: the spawn position is occupied
//   clear_done      single-cycle pulse from the row-clear engine
//   clear_count     rows cleared (0-4); valid with clear_done
//   state           NEW=0, DRO=1, DEL=2, OVER=3
//   del_to_dro      single-cycle pulse that restarts the drop timer
//   spawn/move_down/lock  single-cycle piece command pulses
//   level, lines, score   game statistics (saturating)
//
// Every output is registered.
module tetris_game_ctrl #(
    parameter int MAX_LEVEL       = 15,
    parameter int LINES_PER_LEVEL = 10,
    parameter int DEL_TIMEOUT     = 1023,
    parameter int SCORE_MAX       = 999999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        drop,
    input  logic        collide_below,
    input  logic        spawn_blocked,
    input  logic        clear_done,
    input  logic [2:0]  clear_count,
    output logic [1:0]  state,
    output logic        del_to_dro,
    output logic        spawn,
    output logic        move_down,
    output logic        lock,
    output logic [3:0]  level,
    output logic [9:0]  lines,
    output logic [19:0] score
);

    typedef enum logic [1:0] {
        S_NEW  = 2'd0,
        S_DRO  = 2'd1,
        S_DEL  = 2'd2,
        S_OVER = 2'd3
    } state_t;

    localparam int CW = $clog2(DEL_TIMEOUT + 1);
    // The lines-in-level counter briefly holds up to LINES_PER_LEVEL+3.
    localparam int LW = $clog2(LINES_PER_LEVEL + 4);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [LW-1:0]  lil_q, lil_d, lil_sum;
    logic [3:0]     level_d;
    logic [9:0]     lines_d;
    logic [19:0]    score_d;
    logic           spawn_d, move_down_d, lock_d, del_to_dro_d;

    logic [2:0]     n;
    logic [10:0]    base;
    logic [4:0]     lvl_p1;
    logic [15:0]    prod;
    logic [10:0]    lines_sum;
    logic [20:0]    score_sum;
    logic           timeout;

    assign state   = state_q;
    assign cnt_inc = cnt_q + CW'(1);
    assign timeout = (cnt_inc == CW'(DEL_TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_OVER;
            cnt_q      <= '0;
            lil_q      <= '0;
            level      <= '0;
            lines      <= '0;
            score      <= '0;
            spawn      <= 1'b0;
            move_down  <= 1'b0;
            lock       <= 1'b0;
            del_to_dro <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lil_q      <= lil_d;
            level      <= level_d;
            lines      <= lines_d;
            score      <= score_d;
            spawn      <= spawn_d;
            move_down  <= move_down_d;
            lock       <= lock_d;
            del_to_dro <= del_to_dro_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lil_d        = lil_q;
        level_d      = level;
        lines_d      = lines;
        score_d      = score;
        spawn_d      = 1'b0;
        move_down_d  = 1'b0;
        lock_d       = 1'b0;
        del_to_dro_d = 1'b0;

        // Rows credited on DEL exit. A timeout counts as 0 rows, and
        // out-of-range counts are clamped to 4.
        n = 3'd0;
        if (clear_done) n = (clear_count > 3'd4) ? 3'd4 : clear_count;

        case (n)
            3'd1:    base = 11'd40;
            3'd2:    base = 11'd100;
            3'd3:    base = 11'd300;
            3'd4:    base = 11'd1200;
            default: base = 11'd0;
        endcase

        // Scoring uses the level in force before this clear.
        lvl_p1    = {1'b0, level} + 5'd1;
        prod      = 16'(base) * 16'(lvl_p1);
        score_sum = 21'(score) + 21'(prod);
        lines_sum = 11'(lines) + 11'(n);
        lil_sum   = lil_q + LW'(n);

        case (state_q)
            S_OVER: begin
                if (start) begin
                    level_d = '0;
                    lines_d = '0;
                    score_d = '0;
                    lil_d   = '0;
                    state_d = S_NEW;
                end
            end
            S_NEW: begin
                // drop is ignored here because the timer is being restarted.
                if (spawn_blocked) begin
                    state_d = S_OVER;
                end else begin
                    state_d      = S_DRO;
                    spawn_d      = 1'b1;
                    del_to_dro_d = 1'b1;
                end
            end
            S_DRO: begin
                if (drop) begin
                    if (collide_below) begin
                        lock_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = S_DEL;
                    end else begin
                        move_down_d = 1'b1;
                    end
                end
            end
            default: begin // S_DEL
                cnt_d = cnt_inc;
                if (clear_done || timeout) begin
                    state_d = S_NEW;
                    lines_d = (lines_sum > 11'd999) ? 10'd999 : lines_sum[9:0];
                    score_d = (score_sum > 21'(SCORE_MAX)) ? 20'(SCORE_MAX)
                                                           : score_sum[19:0];
                    if (lil_sum >= LW'(LINES_PER_LEVEL)) begin
                        lil_d = lil_sum - LW'(LINES_PER_LEVEL);
                        if (level < 4'(MAX_LEVEL)) level_d = level + 4'd1;
                    end else begin
                        lil_d = lil_sum;
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_tetris_game_ctrl.sv
// Directed self-checking bench for tetris_game_ctrl.
module tb_tetris_game_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, drop, collide_below, spawn_blocked, clear_done;
    logic [2:0]  clear_count;
    logic [1:0]  state;
    logic        del_to_dro, spawn, move_down, lock;
    logic [3:0]  level;
    logic [9:0]  lines;
    logic [19:0] score;

    int checks = 0;
    int errors = 0;

    tetris_game_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .drop(drop),
        .collide_below(collide_below), .spawn_blocked(spawn_blocked),
        .clear_done(clear_done), .clear_count(clear_count),
        .state(state), .del_to_dro(del_to_dro), .spawn(spawn),
        .move_down(move_down), .lock(lock), .level(level),
        .lines(lines), .score(score)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Lock the current piece, clear n rows, and return to DRO.
    task automatic do_clear(input logic [2:0] n);
        drop = 1'b1; collide_below = 1'b1;
        tick();
        drop = 1'b0; collide_below = 1'b0;
        clear_done = 1'b1; clear_count = n;
        tick();
        clear_done = 1'b0; clear_count = 3'd0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; drop = 0; collide_below = 0;
        spawn_blocked = 0; clear_done = 0; clear_count = 0;
        tick();
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL reset_state got %0d exp 3", state); end
        checks++; if ({level, lines, score} !== 34'd0) begin errors++; $display("FAIL reset_stats got %0d/%0d/%0d exp 0/0/0", level, lines, score); end
        checks++; if ({spawn, move_down, lock, del_to_dro} !== 4'b0) begin errors++; $display("FAIL reset_pulses got %b exp 0000", {spawn, move_down, lock, del_to_dro}); end
        @(negedge clk); rst = 1'b0;
        tick();
    endtask

    task automatic test_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (state !== 2'd0 || spawn !== 1'b0) begin errors++; $display("FAIL start_new got state %0d spawn %b exp 0 0", state, spawn); end
        drop = 1'b1;            // drop during NEW must be ignored
        tick();
        drop = 1'b0;
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL start_dro got %0d exp 1", state); end
        checks++; if (spawn !== 1'b1 || del_to_dro !== 1'b1) begin errors++; $display("FAIL start_pulses got spawn %b d2d %b exp 1 1", spawn, del_to_dro); end
        checks++; if (move_down !== 1'b0) begin errors++; $display("FAIL start_drop_ignored got %b exp 0", move_down); end
        checks++; if (level !== 4'd0 || score !== 20'd0) begin errors++; $display("FAIL start_stats got %0d/%0d exp 0/0", level, score); end
        tick();
        checks++; if (spawn !== 1'b0 || del_to_dro !== 1'b0) begin errors++; $display("FAIL start_pulse_width got spawn %b d2d %b exp 0 0", spawn, del_to_dro); end
    endtask

    task automatic test_move_down();
        for (int i = 0; i < 3; i++) begin
            drop = 1'b1;
            tick();
            drop = 1'b0;
            checks++; if (move_down !== 1'b1 || lock !== 1'b0 || state !== 2'd1) begin errors++; $display("FAIL move_down%0d got md %b lock %b state %0d exp 1 0 1", i, move_down, lock, state); end
            tick();
            checks++; if (move_down !== 1'b0) begin errors++; $display("FAIL move_down_width%0d got %b exp 0", i, move_down); end
        end
    endtask

    task automatic test_clear4();
        drop = 1'b1; collide_below = 1'b1;
        tick();
        drop = 1'b0; collide_below = 1'b0;
        checks++; if (lock !== 1'b1 || move_down !== 1'b0 || state !== 2'd2) begin errors++; $display("FAIL lock got lock %b md %b state %0d exp 1 0 2", lock, move_down, state); end
        clear_done = 1'b1; clear_count = 3'd4;
        tick();
        clear_done = 1'b0; clear_count = 3'd0;
        checks++; if (state !== 2'd0 || lock !== 1'b0) begin errors++; $display("FAIL clear4_new got state %0d lock %b exp 0 0", state, lock); end
        checks++; if (lines !== 10'd4 || score !== 20'd1200) begin errors++; $display("FAIL clear4_stats got %0d/%0d exp 4/1200", lines, score); end
        tick();
        checks++; if (state !== 2'd1 || del_to_dro !== 1'b1 || spawn !== 1'b1) begin errors++; $display("FAIL clear4_respawn got state %0d d2d %b spawn %b exp 1 1 1", state, del_to_dro, spawn); end
    endtask

    task automatic test_level_up();
        do_clear(3'd4);
        checks++; if (level !== 4'd0 || lines !== 10'd8 || score !== 20'd2400) begin errors++; $display("FAIL lvl_second got %0d/%0d/%0d exp 0/8/2400", level, lines, score); end
        do_clear(3'd2);
        checks++; if (level !== 4'd1 || lines !== 10'd10 || score !== 20'd2500) begin errors++; $display("FAIL lvl_third got %0d/%0d/%0d exp 1/10/2500", level, lines, score); end
        // A count above 4 scores as a tetris: 1200 * (1+1).
        do_clear(3'd7);
        checks++; if (lines !== 10'd14 || score !== 20'd4900) begin errors++; $display("FAIL clamp_count got %0d/%0d exp 14/4900", lines, score); end
    endtask

    task automatic test_timeout();
        drop = 1'b1; collide_below = 1'b1;
        tick();
        drop = 1'b0; collide_below = 1'b0;
        repeat (1022) tick();
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL timeout_early got %0d exp 2", state); end
        tick();
        checks++; if (state !== 2'd0 || lines !== 10'd14 || score !== 20'd4900) begin errors++; $display("FAIL timeout got %0d/%0d/%0d exp 0/14/4900", state, lines, score); end
        tick();
        // clear_done on the same cycle as the timeout: the clear is credited.
        drop = 1'b1; collide_below = 1'b1;
        tick();
        drop = 1'b0; collide_below = 1'b0;
        repeat (1022) tick();
        clear_done = 1'b1; clear_count = 3'd1;
        tick();
        clear_done = 1'b0; clear_count = 3'd0;
        checks++; if (state !== 2'd0 || lines !== 10'd15 || score !== 20'd4980) begin errors++; $display("FAIL timeout_tie got %0d/%0d/%0d exp 0/15/4980", state, lines, score); end
        tick();
    endtask

    task automatic test_game_over();
        drop = 1'b1; collide_below = 1'b1;
        tick();
        drop = 1'b0; collide_below = 1'b0;
        clear_done = 1'b1; clear_count = 3'd0;
        tick();
        clear_done = 1'b0;
        spawn_blocked = 1'b1;
        tick();
        checks++; if (state !== 2'd3 || spawn !== 1'b0 || del_to_dro !== 1'b0) begin errors++; $display("FAIL over got state %0d spawn %b d2d %b exp 3 0 0", state, spawn, del_to_dro); end
        checks++; if (lines !== 10'd15 || score !== 20'd4980) begin errors++; $display("FAIL over_hold got %0d/%0d exp 15/4980", lines, score); end
        spawn_blocked = 1'b0;
        drop = 1'b1;
        tick();
        drop = 1'b0;
        checks++; if (state !== 2'd3 || move_down !== 1'b0) begin errors++; $display("FAIL over_idle got state %0d md %b exp 3 0", state, move_down); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (state !== 2'd0 || {level, lines, score} !== 34'd0) begin errors++; $display("FAIL restart got %0d %0d/%0d/%0d exp 0 0/0/0", state, level, lines, score); end
        tick();
        checks++; if (state !== 2'd1 || spawn !== 1'b1) begin errors++; $display("FAIL restart_dro got %0d spawn %b exp 1 1", state, spawn); end
    endtask

    task automatic test_saturation();
        int e_score = 0, e_lines = 0, e_level = 0, e_lil = 0, it = 0;
        while (it < 400 && (e_score < 999999 || e_level < 15)) begin
            do_clear(3'd4);
            e_score = e_score + 1200 * (e_level + 1);
            if (e_score > 999999) e_score = 999999;
            e_lines = (e_lines + 4 > 999) ? 999 : e_lines + 4;
            e_lil   = e_lil + 4;
            if (e_lil >= 10) begin
                e_lil = e_lil - 10;
                if (e_level < 15) e_level++;
            end
            it++;
        end
        do_clear(3'd4);   // one more clear at the ceiling
        e_lines = e_lines + 4;
        checks++; if (score !== 20'd999999) begin errors++; $display("FAIL score_sat got %0d exp 999999", score); end
        checks++; if (level !== 4'd15) begin errors++; $display("FAIL level_sat got %0d exp 15", level); end
        checks++; if (lines !== 10'(e_lines)) begin errors++; $display("FAIL lines_total got %0d exp %0d", lines, e_lines); end
    endtask

    task automatic test_reset_mid();
        drop = 1'b1;
        tick();
        drop = 1'b0;
        checks++; if (move_down !== 1'b1) begin errors++; $display("FAIL pre_reset_md got %b exp 1", move_down); end
        #2 rst = 1'b1;
        #1;
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL async_reset_state got %0d exp 3", state); end
        checks++; if ({spawn, move_down, lock, del_to_dro} !== 4'b0 || {level, lines, score} !== 34'd0) begin errors++; $display("FAIL async_reset_outs got %b %0d/%0d/%0d exp 0000 0/0/0", {spawn, move_down, lock, del_to_dro}, level, lines, score); end
        @(negedge clk); rst = 1'b0;
        tick();
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL post_reset_idle got %0d exp 3", state); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_move_down();
        test_clear4();
        test_level_up();
        test_timeout();
        test_game_over();
        test_saturation();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
